apb_m: RTL and testbench
========================

# apb_m

APB requester that turns single commands from a local valid/ready port into APB SETUP/ACCESS transfers toward an APB completer such as the 16×8 register-file slave. It holds one transfer in flight, honours completer wait states via `pready`, and returns read data and error status on a one-cycle response strobe. It sits between the system controller or test sequencer and the APB segment.

## Interface
- `ADDR_W`, 4, width of `cmd_addr` and `paddr`
- `DATA_W`, 8, width of write/read data
- `TIMEOUT`, 15, maximum ACCESS cycles with `pready` low before abort (used only with `APB_M_TIMEOUT_EN`); must be ≥1

- `pclk` in 1, clock; all logic on rising edge
- `presetn` in 1, reset, asynchronous, active-low
- `cmd_valid` in 1, command request
- `cmd_ready` out 1, requester idle, command accepted when `cmd_valid && cmd_ready` at an edge
- `cmd_write` in 1, 1 = write, 0 = read
- `cmd_addr` in ADDR_W, target address
- `cmd_wdata` in DATA_W, write data
- `rsp_valid` out 1, one-cycle completion strobe
- `rsp_rdata` out DATA_W, read data (0 for writes and aborts)
- `rsp_err` out 1, `pslverr` or timeout, qualified by `rsp_valid`
- `paddr` out ADDR_W, APB address
- `psel` out 1, APB select
- `penable` out 1, APB enable
- `pwrite` out 1, APB direction
- `pwdata` out DATA_W, APB write data
- `prdata` in DATA_W, APB read data
- `pready` in 1, completer ready
- `pslverr` in 1, completer error; tie 0 for completers without it

## Operation
- States: IDLE, SETUP, ACCESS. Reset → IDLE.
- IDLE: `cmd_ready`=1, `psel`=`penable`=0. On accept: register `cmd_write`/`cmd_addr`/`cmd_wdata` onto `pwrite`/`paddr`/`pwdata`, `cmd_ready`→0, → SETUP.
- SETUP: `psel`=1, `penable`=0; unconditionally → ACCESS.
- ACCESS: `psel`=1, `penable`=1; stay while `pready`=0. When `pready`=1: `rsp_valid`→1 next cycle, `rsp_rdata`←`prdata` for reads else 0, `rsp_err`←`pslverr`; `psel`/`penable`→0, `cmd_ready`→1, → IDLE.
- `paddr`, `pwrite`, `pwdata` stable from SETUP through last ACCESS cycle; they keep last values in IDLE.
- Command inputs ignored while `cmd_ready`=0. No back-to-back transfer: IDLE always separates transfers.
- `rsp_valid` high exactly one cycle per accepted command; `rsp_rdata`/`rsp_err` held until next response.
- Reset during SETUP/ACCESS: `psel`/`penable` drop immediately (async), transfer discarded, no `rsp_valid`.

## Timing
- All outputs registered. Reset values: `cmd_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `psel`=0, `penable`=0, `pwrite`=0, `paddr`=0, `pwdata`=0.
- Accept at edge E0: SETUP during cycle E0–E1, ACCESS from E1. `pready` high sampled at E2 → `rsp_valid` and `cmd_ready` high in cycle E2–E3. Zero-wait latency accept→response = 2 cycles; each wait state adds 1.
- Minimum command rate: one per 3 cycles.

## Configuration
- `APB_M_TIMEOUT_EN` defined: counter clears on entering ACCESS, increments each ACCESS cycle with `pready`=0; on reaching `TIMEOUT` with `pready` still 0, abort → IDLE with `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0. `pready` high on the same edge wins (normal completion).
- Not defined: no counter; ACCESS waits indefinitely for `pready`.

## Test plan
- Write addr 3 data 0xA5, `pready` high in first ACCESS → `psel` 2 cycles, `penable` 1 cycle, `pwdata`=0xA5, `rsp_valid` at E2, `rsp_err`=0.
- Read addr 3 after that write into register-file slave → `rsp_rdata`=0xA5, `rsp_err`=0.
- Read with 3 wait states → ACCESS held 4 cycles, `paddr`/`pwrite` stable, `rsp_valid` 5 cycles after accept, single pulse.
- `pslverr`=1 with `pready` on a write → `rsp_err`=1, `rsp_rdata`=0; `cmd_valid` held during transfer not accepted until `cmd_ready`=1.
- With `APB_M_TIMEOUT_EN`, `TIMEOUT`=15, `pready` tied 0 → abort after 15 ACCESS cycles, `rsp_err`=1, `psel`=0 next cycle.
- Assert `presetn` low during ACCESS → `psel`=`penable`=0 immediately, no `rsp_valid`, `cmd_ready`=1 after release.

Source files
------------

// File: rtl/apb_m.sv
// APB requester: one local command in flight as SETUP/ACCESS, one-cycle rsp strobe; APB_M_TIMEOUT_EN adds ACCESS abort.
// Latency accept->rsp_valid 2 cycles plus one per wait state; cmd_ready low from accept until the response cycle.
module apb_m #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;

`ifdef APB_M_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`else
  logic                unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    paddr_d     = paddr_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
`ifdef APB_M_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          paddr_d     = cmd_addr;
          pwrite_d    = cmd_write;
          pwdata_d    = cmd_wdata;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_M_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
`ifdef APB_M_TIMEOUT_EN
        // The edge that ends the TIMEOUT-th stalled ACCESS cycle aborts.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d     = IDLE;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      paddr_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
`ifdef APB_M_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
`ifdef APB_M_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_m.sv
// Directed bench for apb_m driving a 16x8 register-file completer model.
// Each scenario task drives stimulus and checks outputs 1 time unit after the rising edge.
module tb_apb_m;

  logic       pclk;
  logic       presetn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [3:0] paddr;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  int n_checks = 0;
  int n_fail   = 0;

  apb_m #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(15)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Register-file completer: writes commit on the ACCESS edge with pready high.
  logic [7:0] mem [16];
  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else if (psel && penable && pready && pwrite) begin
      mem[paddr] <= pwdata;
    end
  end
  assign prdata = mem[paddr];

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'h0;
    cmd_wdata = 8'h00; pready = 1'b0; pslverr = 1'b0;
    #12;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rsp_rdata got %h exp 00", rsp_rdata); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err got %b exp 0", rsp_err); end
    n_checks++; if (psel !== 1'b0) begin n_fail++; $display("FAIL rst_psel got %b exp 0", psel); end
    n_checks++; if (penable !== 1'b0) begin n_fail++; $display("FAIL rst_penable got %b exp 0", penable); end
    n_checks++; if (pwrite !== 1'b0) begin n_fail++; $display("FAIL rst_pwrite got %b exp 0", pwrite); end
    n_checks++; if (paddr !== 4'h0) begin n_fail++; $display("FAIL rst_paddr got %h exp 0", paddr); end
    n_checks++; if (pwdata !== 8'h00) begin n_fail++; $display("FAIL rst_pwdata got %h exp 00", pwdata); end
    tick();
    presetn = 1'b1;
    tick();
  endtask

  task automatic test_write();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h3; cmd_wdata = 8'hA5; pready = 1'b1;
    tick(); // E0: accepted, SETUP
    cmd_valid = 1'b0;
    n_checks++; if (psel !== 1'b1 || penable !== 1'b0) begin n_fail++; $display("FAIL wr_setup psel/penable got %b/%b exp 1/0", psel, penable); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL wr_cmd_ready_busy got %b exp 0", cmd_ready); end
    n_checks++; if (paddr !== 4'h3 || pwrite !== 1'b1 || pwdata !== 8'hA5) begin n_fail++; $display("FAIL wr_setup_bus got %h/%b/%h exp 3/1/a5", paddr, pwrite, pwdata); end
    tick(); // E1: ACCESS
    n_checks++; if (psel !== 1'b1 || penable !== 1'b1) begin n_fail++; $display("FAIL wr_access psel/penable got %b/%b exp 1/1", psel, penable); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_early got %b exp 0", rsp_valid); end
    tick(); // E2: response
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL wr_rsp got v%b e%b d%h exp v1 e0 d00", rsp_valid, rsp_err, rsp_rdata); end
    n_checks++; if (psel !== 1'b0 || penable !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_idle got psel%b pen%b rdy%b exp 0 0 1", psel, penable, cmd_ready); end
    tick(); // E3
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_pulse got %b exp 0", rsp_valid); end
    n_checks++; if (paddr !== 4'h3 || pwdata !== 8'hA5) begin n_fail++; $display("FAIL wr_idle_hold got %h/%h exp 3/a5", paddr, pwdata); end
  endtask

  task automatic test_read();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h3; cmd_wdata = 8'hFF; pready = 1'b1;
    tick(); // E0
    cmd_valid = 1'b0;
    n_checks++; if (pwrite !== 1'b0 || paddr !== 4'h3) begin n_fail++; $display("FAIL rd_setup_bus got %b/%h exp 0/3", pwrite, paddr); end
    tick(); // E1
    tick(); // E2
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rd_rsp got v%b d%h e%b exp v1 da5 e0", rsp_valid, rsp_rdata, rsp_err); end
    tick();
  endtask

  task automatic test_wait_states();
    // Store 0x3C at addr 9 first, zero-wait.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h9; cmd_wdata = 8'h3C; pready = 1'b1;
    tick(); cmd_valid = 1'b0; tick(); tick(); tick();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h9; cmd_wdata = 8'h00; pready = 1'b0;
    tick(); // E0
    cmd_valid = 1'b0; cmd_addr = 4'h1; cmd_write = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(); // E1..E4: ACCESS
      n_checks++; if (psel !== 1'b1 || penable !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ws_access%0d got psel%b pen%b v%b exp 1 1 0", i, psel, penable, rsp_valid); end
      n_checks++; if (paddr !== 4'h9 || pwrite !== 1'b0) begin n_fail++; $display("FAIL ws_stable%0d got %h/%b exp 9/0", i, paddr, pwrite); end
      if (i == 4) pready = 1'b1;
    end
    tick(); // E5
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h3C) begin n_fail++; $display("FAIL ws_rsp got v%b d%h exp v1 d3c", rsp_valid, rsp_rdata); end
    tick(); // E6
    n_checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h3C) begin n_fail++; $display("FAIL ws_pulse_hold got v%b d%h exp v0 d3c", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_slverr_busy();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h2; cmd_wdata = 8'h77;
    pready = 1'b1; pslverr = 1'b1;
    tick(); // E0: accept write; cmd_valid stays high with a new read command
    cmd_write = 1'b0; cmd_addr = 4'hE; cmd_wdata = 8'h11;
    tick(); // E1
    n_checks++; if (paddr !== 4'h2 || pwrite !== 1'b1 || pwdata !== 8'h77) begin n_fail++; $display("FAIL err_busy_ignore got %h/%b/%h exp 2/1/77", paddr, pwrite, pwdata); end
    tick(); // E2
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL err_rsp got v%b e%b d%h exp v1 e1 d00", rsp_valid, rsp_err, rsp_rdata); end
    n_checks++; if (psel !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL err_no_b2b got psel%b rdy%b exp 0 1", psel, cmd_ready); end
    pslverr = 1'b0;
    tick(); // E3: held command accepted now
    cmd_valid = 1'b0;
    n_checks++; if (psel !== 1'b1 || paddr !== 4'hE || pwrite !== 1'b0) begin n_fail++; $display("FAIL err_next_accept got psel%b %h/%b exp 1 e/0", psel, paddr, pwrite); end
    n_checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b1) begin n_fail++; $display("FAIL err_hold got v%b e%b exp v0 e1", rsp_valid, rsp_err); end
    tick(); tick(); // E5
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL err_next_rsp got v%b e%b d%h exp v1 e0 d00", rsp_valid, rsp_err, rsp_rdata); end
    tick();
  endtask

`ifdef APB_M_TIMEOUT_EN
  task automatic test_timeout();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h3; pready = 1'b0;
    tick(); // E0
    cmd_valid = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick(); // E1..E15: still in ACCESS
      n_checks++; if (psel !== 1'b1 || penable !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL to_access%0d got psel%b pen%b v%b exp 1 1 0", i, psel, penable, rsp_valid); end
    end
    tick(); // E16: abort
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL to_rsp got v%b e%b d%h exp v1 e1 d00", rsp_valid, rsp_err, rsp_rdata); end
    n_checks++; if (psel !== 1'b0 || penable !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL to_idle got psel%b pen%b rdy%b exp 0 0 1", psel, penable, cmd_ready); end
    pready = 1'b1;
    tick();
  endtask
`else
  task automatic test_no_timeout();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h3; pready = 1'b0;
    tick(); // E0
    cmd_valid = 1'b0;
    for (int i = 0; i < 21; i++) tick();
    n_checks++; if (psel !== 1'b1 || penable !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL nto_wait got psel%b pen%b v%b exp 1 1 0", psel, penable, rsp_valid); end
    pready = 1'b1;
    tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 8'hA5) begin n_fail++; $display("FAIL nto_rsp got v%b e%b d%h exp v1 e0 da5", rsp_valid, rsp_err, rsp_rdata); end
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4; cmd_wdata = 8'h5A; pready = 1'b0;
    tick(); // E0
    cmd_valid = 1'b0;
    tick(); // E1: ACCESS
    n_checks++; if (psel !== 1'b1 || penable !== 1'b1) begin n_fail++; $display("FAIL rm_pre got psel%b pen%b exp 1 1", psel, penable); end
    #2 presetn = 1'b0;
    #1;
    n_checks++; if (psel !== 1'b0 || penable !== 1'b0) begin n_fail++; $display("FAIL rm_async_drop got psel%b pen%b exp 0 0", psel, penable); end
    pready = 1'b1;
    tick(); tick();
    presetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (rsp_valid !== 1'b0 || psel !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rm_after%0d got v%b psel%b rdy%b exp 0 0 1", i, rsp_valid, psel, cmd_ready); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wait_states();
    test_slverr_busy();
`ifdef APB_M_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
